// File: rtl/decode_pkg.sv
// Shared types and constants for the miniRV decode stage.
// Holds the forward-source selector and the default datapath sizes.
package decode_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREG_DEF   = 32;
  localparam int CTRL_W_DEF = 20;
  localparam int PERF_W_DEF = 32;

  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_WB,
    FWD_MEM,
    FWD_EX
  } fwd_sel_e;

  // The youngest producer wins, so EX is checked before MEM and MEM before WB.
  function automatic fwd_sel_e fwdSel(input logic exHit, input logic memHit, input logic wbHit);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (exHit)       sel = FWD_EX;
    else if (memHit) sel = FWD_MEM;
    else if (wbHit)  sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: two combinational read ports, one write port.
// x0 is hardwired to zero by discarding every write aimed at it.
module id_regfile
  import decode_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   i_rAddr1,
  input  logic [AW-1:0]   i_rAddr2,
  output logic [XLEN-1:0] o_rData1,
  output logic [XLEN-1:0] o_rData2,
  input  logic            i_we,
  input  logic [AW-1:0]   i_wAddr,
  input  logic [XLEN-1:0] i_wData
);

  logic [XLEN-1:0] r_regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (i_we && (i_wAddr != AW'(REG_ZERO))) begin
      r_regs[i_wAddr] <= i_wData;
    end
  end

  assign o_rData1 = r_regs[i_rAddr1];
  assign o_rData2 = r_regs[i_rAddr2];

endmodule

// File: rtl/id_stage_pipe.sv
// miniRV decode stage: register file, EX>MEM>WB>RF forwarding, load-use bubble, ID/EX register.
// Define DECODE_PERF_EN to build the saturating stall/bubble performance counters.
module id_stage_pipe
  import decode_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int PERF_W = PERF_W_DEF,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [31:0]       id_inst,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_rf_we,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              exf_we,
  input  logic [AW-1:0]     exf_wR,
  input  logic [XLEN-1:0]   exf_wD,
  input  logic              memf_we,
  input  logic [AW-1:0]     memf_wR,
  input  logic [XLEN-1:0]   memf_wD,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_wR,
  input  logic [XLEN-1:0]   wb_wD,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_rD1,
  output logic [XLEN-1:0]   ex_rD2,
  output logic [AW-1:0]     ex_wR,
  output logic              ex_rf_we,
  output logic              load_use_stall,
  output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0] perf_bubble
);

  logic              r_exValid;
  logic [CTRL_W-1:0] r_exCtrl;
  logic [XLEN-1:0]   r_exImm;
  logic [XLEN-1:0]   r_exRD1;
  logic [XLEN-1:0]   r_exRD2;
  logic [AW-1:0]     r_exWR;
  logic              r_exRfWe;
  logic              r_exIsLoad;

  logic [AW-1:0]   w_rs1;
  logic [AW-1:0]   w_rs2;
  logic [XLEN-1:0] w_rf1;
  logic [XLEN-1:0] w_rf2;
  fwd_sel_e        w_sel1;
  fwd_sel_e        w_sel2;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic            w_adv;
  logic            w_loadUse;
  logic            w_idReady;
  logic            w_bubble;
  logic            w_unusedInst;

  assign w_rs1        = id_inst[15 +: AW];
  assign w_rs2        = id_inst[20 +: AW];
  assign w_unusedInst = ^id_inst;

  id_regfile #(
    .XLEN (XLEN),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .i_rAddr1 (w_rs1),
    .i_rAddr2 (w_rs2),
    .o_rData1 (w_rf1),
    .o_rData2 (w_rf2),
    .i_we     (wb_we),
    .i_wAddr  (wb_wR),
    .i_wData  (wb_wD)
  );

  function automatic logic [XLEN-1:0] fwdData(input fwd_sel_e sel, input logic isZero,
                                              input logic [XLEN-1:0] rf, input logic [XLEN-1:0] ex,
                                              input logic [XLEN-1:0] mem, input logic [XLEN-1:0] wb);
    logic [XLEN-1:0] d;
    case (sel)
      FWD_EX:  d = ex;
      FWD_MEM: d = mem;
      FWD_WB:  d = wb;
      default: d = rf;
    endcase
    if (isZero) d = '0;
    return d;
  endfunction

  always_comb begin
    w_sel1 = fwdSel(exf_we && (exf_wR == w_rs1), memf_we && (memf_wR == w_rs1), wb_we && (wb_wR == w_rs1));
    w_sel2 = fwdSel(exf_we && (exf_wR == w_rs2), memf_we && (memf_wR == w_rs2), wb_we && (wb_wR == w_rs2));
    w_op1  = fwdData(w_sel1, w_rs1 == AW'(REG_ZERO), w_rf1, exf_wD, memf_wD, wb_wD);
    w_op2  = fwdData(w_sel2, w_rs2 == AW'(REG_ZERO), w_rf2, exf_wD, memf_wD, wb_wD);
  end

  // A load still in EX cannot forward yet, so a dependent reader must wait one slot.
  assign w_loadUse = id_valid && r_exValid && r_exIsLoad && r_exRfWe && (r_exWR != AW'(REG_ZERO)) &&
                     ((id_use_rs1 && (w_rs1 == r_exWR)) || (id_use_rs2 && (w_rs2 == r_exWR)));

  assign w_adv     = !r_exValid || ex_ready;
  assign w_idReady = flush || (w_adv && !w_loadUse);
  assign w_bubble  = !flush && w_adv && w_loadUse;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exValid  <= 1'b0;
      r_exCtrl   <= '0;
      r_exImm    <= '0;
      r_exRD1    <= '0;
      r_exRD2    <= '0;
      r_exWR     <= '0;
      r_exRfWe   <= 1'b0;
      r_exIsLoad <= 1'b0;
    end else if (flush) begin
      r_exValid <= 1'b0;
    end else if (w_bubble) begin
      r_exValid  <= 1'b0;
      r_exRfWe   <= 1'b0;
      r_exIsLoad <= 1'b0;
    end else if (w_adv) begin
      r_exValid  <= id_valid;
      r_exCtrl   <= id_ctrl;
      r_exImm    <= id_imm;
      r_exRD1    <= w_op1;
      r_exRD2    <= w_op2;
      r_exWR     <= id_inst[7 +: AW];
      r_exRfWe   <= id_rf_we && id_valid;
      r_exIsLoad <= id_is_load && id_valid;
    end
  end

`ifdef DECODE_PERF_EN
  logic [PERF_W-1:0] r_perfStall;
  logic [PERF_W-1:0] r_perfBubble;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perfStall  <= '0;
      r_perfBubble <= '0;
    end else begin
      if (id_valid && !w_idReady && (r_perfStall != '1)) r_perfStall <= r_perfStall + 1'b1;
      if (w_bubble && (r_perfBubble != '1)) r_perfBubble <= r_perfBubble + 1'b1;
    end
  end

  assign perf_stall  = r_perfStall;
  assign perf_bubble = r_perfBubble;
`else
  assign perf_stall  = '0;
  assign perf_bubble = '0;
`endif

  assign id_ready       = w_idReady;
  assign load_use_stall = w_loadUse;
  assign ex_valid       = r_exValid;
  assign ex_ctrl        = r_exCtrl;
  assign ex_imm         = r_exImm;
  assign ex_rD1         = r_exRD1;
  assign ex_rD2         = r_exRD2;
  assign ex_wR          = r_exWR;
  assign ex_rf_we       = r_exRfWe;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed stimulus with a scoreboard of expected ID/EX contents.
// Counter checks follow DECODE_PERF_EN (expected zero when the macro is undefined).
module tb_id_stage_pipe;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 20;
  localparam int AW     = 5;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rD1;
    logic [XLEN-1:0]   rD2;
    logic [AW-1:0]     wR;
    logic              rfWe;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_ready;
  logic [31:0] id_inst;
  logic [CTRL_W-1:0] id_ctrl;
  logic [XLEN-1:0] id_imm;
  logic id_use_rs1, id_use_rs2, id_rf_we, id_is_load, flush;
  logic exf_we, memf_we, wb_we;
  logic [AW-1:0] exf_wR, memf_wR, wb_wR;
  logic [XLEN-1:0] exf_wD, memf_wD, wb_wD;
  logic ex_ready, ex_valid, ex_rf_we, load_use_stall;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [XLEN-1:0] ex_imm, ex_rD1, ex_rD2;
  logic [AW-1:0] ex_wR;
  logic [31:0] perf_stall, perf_bubble;

  exp_t sbQueue[$];
  int checkCount = 0;
  int failCount  = 0;
  logic [AW-1:0] curRd;

  id_stage_pipe dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_ctrl(id_ctrl), .id_imm(id_imm),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rf_we(id_rf_we), .id_is_load(id_is_load),
    .flush(flush),
    .exf_we(exf_we), .exf_wR(exf_wR), .exf_wD(exf_wD),
    .memf_we(memf_we), .memf_wR(memf_wR), .memf_wD(memf_wD),
    .wb_we(wb_we), .wb_wR(wb_wR), .wb_wD(wb_wD),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_imm(ex_imm),
    .ex_rD1(ex_rD1), .ex_rD2(ex_rD2), .ex_wR(ex_wR), .ex_rf_we(ex_rf_we),
    .load_use_stall(load_use_stall), .perf_stall(perf_stall), .perf_bubble(perf_bubble)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                               input logic [AW-1:0] rd, input logic use1, input logic use2,
                               input logic rfWe, input logic isLoad,
                               input logic [CTRL_W-1:0] ctrl, input logic [XLEN-1:0] imm);
    id_valid   = valid;
    id_inst    = {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
    curRd      = rd;
    id_use_rs1 = use1;
    id_use_rs2 = use2;
    id_rf_we   = rfWe;
    id_is_load = isLoad;
    id_ctrl    = ctrl;
    id_imm     = imm;
  endtask

  // Record what the currently presented instruction must look like once it reaches EX.
  task automatic expectCapture(input logic [XLEN-1:0] rD1, input logic [XLEN-1:0] rD2);
    exp_t e;
    e.ctrl = id_ctrl;
    e.imm  = id_imm;
    e.rD1  = rD1;
    e.rD2  = rD2;
    e.wR   = curRd;
    e.rfWe = id_rf_we;
    sbQueue.push_back(e);
  endtask

  task automatic wbWrite(input logic [AW-1:0] r, input logic [XLEN-1:0] d);
    wb_we = 1'b1;
    wb_wR = r;
    wb_wD = d;
    tick();
    wb_we = 1'b0;
  endtask

  // Compare the ID/EX contents against the scoreboard whenever EX consumes them.
  always @(negedge clk) begin
    if (!rst && ex_valid && ex_ready) begin
      if (sbQueue.size() == 0) begin
        checkOutput("sb_underflow", 32'(sbQueue.size()), 32'd1);
      end else begin
        exp_t e;
        e = sbQueue.pop_front();
        checkOutput("sb_ctrl", 32'(ex_ctrl), 32'(e.ctrl));
        checkOutput("sb_imm", ex_imm, e.imm);
        checkOutput("sb_rD1", ex_rD1, e.rD1);
        checkOutput("sb_rD2", ex_rD2, e.rD2);
        checkOutput("sb_wR", 32'(ex_wR), 32'(e.wR));
        checkOutput("sb_rfWe", 32'(ex_rf_we), 32'(e.rfWe));
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    exf_we = 1'b0; exf_wR = '0; exf_wD = '0;
    memf_we = 1'b0; memf_wR = '0; memf_wD = '0;
    wb_we = 1'b0; wb_wR = '0; wb_wD = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, '0, '0);
    tick();
    tick();
    checkOutput("rst_exValid", 32'(ex_valid), 32'd0);
    checkOutput("rst_exCtrl", 32'(ex_ctrl), 32'd0);
    checkOutput("rst_exImm", ex_imm, 32'd0);
    checkOutput("rst_exRD1", ex_rD1, 32'd0);
    checkOutput("rst_exRD2", ex_rD2, 32'd0);
    checkOutput("rst_exWR", 32'(ex_wR), 32'd0);
    checkOutput("rst_exRfWe", 32'(ex_rf_we), 32'd0);
    checkOutput("rst_idReady", 32'(id_ready), 32'd1);
    checkOutput("rst_perfStall", perf_stall, 32'd0);
    rst = 1'b0;

    wbWrite(5'd1, 32'h11);
    wbWrite(5'd2, 32'h22);
    wbWrite(5'd6, 32'h66);

    // WB write and same-cycle read of x5
    applyStimulus(1, 5'd5, 5'd2, 5'd7, 1, 1, 1, 0, 20'h000A5, 32'h10);
    wb_we = 1'b1; wb_wR = 5'd5; wb_wD = 32'h1234;
    expectCapture(32'h1234, 32'h22);
    tick();
    checkOutput("t1_latency", 32'(ex_valid), 32'd1);
    wb_we = 1'b0; id_valid = 1'b0;
    tick();
    checkOutput("t1_drain", 32'(ex_valid), 32'd0);

    // Forward priority EX > MEM > WB > RF on x3
    applyStimulus(1, 5'd5, 5'd3, 5'd10, 1, 1, 1, 0, 20'h00111, 32'h1);
    exf_we = 1'b1; exf_wR = 5'd3; exf_wD = 32'h7;
    memf_we = 1'b1; memf_wR = 5'd3; memf_wD = 32'h9;
    wb_we = 1'b1; wb_wR = 5'd3; wb_wD = 32'hBB;
    expectCapture(32'h1234, 32'h7);
    tick();
    exf_we = 1'b0; wb_wD = 32'hCC;
    applyStimulus(1, 5'd5, 5'd3, 5'd11, 1, 1, 1, 0, 20'h00222, 32'h2);
    expectCapture(32'h1234, 32'h9);
    tick();
    memf_we = 1'b0; wb_wD = 32'hDD;
    applyStimulus(1, 5'd5, 5'd3, 5'd12, 1, 1, 1, 0, 20'h00333, 32'h3);
    expectCapture(32'h1234, 32'hDD);
    tick();
    wb_we = 1'b0;
    applyStimulus(1, 5'd5, 5'd3, 5'd13, 1, 1, 1, 0, 20'h00444, 32'h4);
    expectCapture(32'h1234, 32'hDD);
    tick();
    applyStimulus(1, 5'd0, 5'd0, 5'd14, 1, 1, 1, 0, 20'h00555, 32'h5);
    exf_we = 1'b1; exf_wR = 5'd0; exf_wD = 32'hFFFF;
    memf_we = 1'b1; memf_wR = 5'd0; memf_wD = 32'hFFFF;
    wb_we = 1'b1; wb_wR = 5'd0; wb_wD = 32'hFFFF;
    expectCapture(32'h0, 32'h0);
    tick();
    exf_we = 1'b0; memf_we = 1'b0; wb_we = 1'b0; id_valid = 1'b0;
    tick();

    // Load-use: lw x4 then add reading x4
    applyStimulus(1, 5'd1, 5'd0, 5'd4, 1, 0, 1, 1, 20'h00033, 32'h4);
    expectCapture(32'h11, 32'h0);
    tick();
    applyStimulus(0, 5'd4, 5'd2, 5'd8, 1, 1, 1, 0, 20'h00044, 32'h0);
    #1;
    checkOutput("t3_stallGated", 32'(load_use_stall), 32'd0);
    id_valid = 1'b1;
    #1;
    checkOutput("t3_stall", 32'(load_use_stall), 32'd1);
    checkOutput("t3_idReady", 32'(id_ready), 32'd0);
    tick();
    checkOutput("t3_bubble", 32'(ex_valid), 32'd0);
    checkOutput("t3_bubbleRfWe", 32'(ex_rf_we), 32'd0);
    checkOutput("t3_stallGone", 32'(load_use_stall), 32'd0);
    checkOutput("t3_readyAgain", 32'(id_ready), 32'd1);
    memf_we = 1'b1; memf_wR = 5'd4; memf_wD = 32'h44;
    expectCapture(32'h44, 32'h22);
    tick();
    checkOutput("t3_captured", 32'(ex_valid), 32'd1);
    memf_we = 1'b0; id_valid = 1'b0;

    // Back-pressure from EX for three cycles
    applyStimulus(1, 5'd1, 5'd2, 5'd13, 1, 1, 1, 0, 20'h00055, 32'h55);
    expectCapture(32'h11, 32'h22);
    tick();
    ex_ready = 1'b0;
    applyStimulus(1, 5'd6, 5'd1, 5'd14, 1, 1, 1, 0, 20'h00066, 32'h66);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("t4_holdReady", 32'(id_ready), 32'd0);
      checkOutput("t4_holdValid", 32'(ex_valid), 32'd1);
      checkOutput("t4_holdCtrl", 32'(ex_ctrl), 32'h55);
      checkOutput("t4_holdRD1", ex_rD1, 32'h11);
      tick();
    end
    ex_ready = 1'b1;
    #1;
    checkOutput("t4_release", 32'(id_ready), 32'd1);
    expectCapture(32'h66, 32'h11);
    tick();
    checkOutput("t4_nextCtrl", 32'(ex_ctrl), 32'h66);
    id_valid = 1'b0;

    // Flush during a load-use stall on rs2; WB tries to write x0
    applyStimulus(1, 5'd1, 5'd0, 5'd9, 1, 0, 1, 1, 20'h00077, 32'h8);
    expectCapture(32'h11, 32'h0);
    tick();
    applyStimulus(1, 5'd2, 5'd9, 5'd15, 1, 1, 1, 0, 20'h00088, 32'h0);
    #1;
    checkOutput("t5_stall", 32'(load_use_stall), 32'd1);
    checkOutput("t5_stallReady", 32'(id_ready), 32'd0);
    flush = 1'b1;
    wb_we = 1'b1; wb_wR = 5'd0; wb_wD = 32'hFFFF;
    #1;
    checkOutput("t5_flushReady", 32'(id_ready), 32'd1);
    tick();
    checkOutput("t5_flushValid", 32'(ex_valid), 32'd0);
    flush = 1'b0; wb_we = 1'b0;
    applyStimulus(1, 5'd0, 5'd0, 5'd16, 1, 1, 1, 0, 20'h00099, 32'h0);
    expectCapture(32'h0, 32'h0);
    tick();
    id_valid = 1'b0;
    tick();

    // Reset while an instruction sits in EX, together with flush
    ex_ready = 1'b0;
    applyStimulus(1, 5'd1, 5'd2, 5'd17, 1, 1, 1, 0, 20'h000AA, 32'hAA);
    tick();
    rst = 1'b1; flush = 1'b1;
    tick();
    checkOutput("t6_rstValid", 32'(ex_valid), 32'd0);
    checkOutput("t6_rstCtrl", 32'(ex_ctrl), 32'd0);
    checkOutput("t6_rstRD1", ex_rD1, 32'd0);
    checkOutput("t6_rstRfWe", 32'(ex_rf_we), 32'd0);
    rst = 1'b0; flush = 1'b0; ex_ready = 1'b1;

    // One load-use bubble plus one back-pressure cycle for the counters; RF now cleared
    applyStimulus(1, 5'd1, 5'd0, 5'd4, 1, 0, 1, 1, 20'h000B0, 32'h0);
    expectCapture(32'h0, 32'h0);
    tick();
    applyStimulus(1, 5'd4, 5'd0, 5'd5, 1, 0, 1, 0, 20'h000B1, 32'h0);
    #1;
    checkOutput("t6_stall", 32'(load_use_stall), 32'd1);
    tick();
    expectCapture(32'h0, 32'h0);
    tick();
    ex_ready = 1'b0;
    applyStimulus(1, 5'd0, 5'd0, 5'd6, 0, 0, 1, 0, 20'h000B2, 32'h0);
    tick();
    ex_ready = 1'b1; id_valid = 1'b0;
    #1;
`ifdef DECODE_PERF_EN
    checkOutput("t6_perfStall", perf_stall, 32'd2);
    checkOutput("t6_perfBubble", perf_bubble, 32'd1);
`else
    checkOutput("t6_perfStall", perf_stall, 32'd0);
    checkOutput("t6_perfBubble", perf_bubble, 32'd0);
`endif
    tick();
    rst = 1'b1;
    tick();
    checkOutput("t6_perfStallRst", perf_stall, 32'd0);
    checkOutput("t6_perfBubbleRst", perf_bubble, 32'd0);
    rst = 1'b0;
    tick();
    tick();
    checkOutput("sb_empty", 32'(sbQueue.size()), 32'd0);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
